fifo_stim_writer: RTL and testbench

Write-side traffic generator for the block-RAM FIFO experiments: pushes a deterministic incrementing byte stream into the FIFO write port in programmable bursts separated by idle gaps, honouring `full`. Sits between the testbench control and the FIFO `wr`/`w_data` inputs, opposite the read-side checker, so both ends can be exercised with predictable data and back-pressure.

---
 rtl/fifo_stim_writer.sv | 143 ++++++++++++++
 tb/tb_fifo_stim_writer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stim_writer.sv
// Write-side FIFO traffic generator: incrementing bytes in bursts with gaps.
// Optional FIFO_STIM_ERR_INJECT_EN adds inj_err to corrupt bit 0 of a word.
module fifo_stim_writer #(
    parameter int B = 8,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [B-1:0] seed,
    input  logic [15:0]  total,
    input  logic [W:0]   burst_len,
    input  logic [7:0]   gap_len,
    input  logic         full,
`ifdef FIFO_STIM_ERR_INJECT_EN
    input  logic         inj_err,
`endif
    output logic         wr,
    output logic [B-1:0] wr_data,
    output logic         busy,
    output logic         done,
    output logic [15:0]  wr_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BURST,
        S_GAP,
        S_DONE
    } state_e;

    localparam logic [W:0] BONE = {{W{1'b0}}, 1'b1};

    state_e       state_q, state_d;
    logic [B-1:0] data_q, data_d;
    logic [15:0]  total_q, total_d;
    logic [W:0]   blen_q, blen_d;
    logic [7:0]   gap_q, gap_d;
    logic [15:0]  cnt_q, cnt_d;
    logic [W:0]   bcnt_q, bcnt_d;
    logic [7:0]   gcnt_q, gcnt_d;

    logic last_wr;
    logic burst_end;

    assign wr        = (state_q == S_BURST) && !full;
    assign busy      = (state_q == S_BURST) || (state_q == S_GAP);
    assign done      = (state_q == S_DONE);
    assign wr_count  = cnt_q;
    assign last_wr   = ((cnt_q + 16'd1) == total_q);
    assign burst_end = ((bcnt_q + BONE) == blen_q);

`ifdef FIFO_STIM_ERR_INJECT_EN
    assign wr_data = data_q ^ {{(B-1){1'b0}}, inj_err & wr};
`else
    assign wr_data = data_q;
`endif

    // Next-state: run sequencing, data stepping and burst/gap counting.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        total_d = total_q;
        blen_d  = blen_q;
        gap_d   = gap_q;
        cnt_d   = cnt_q;
        bcnt_d  = bcnt_q;
        gcnt_d  = gcnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    data_d  = seed;
                    total_d = total;
                    blen_d  = (burst_len == '0) ? BONE : burst_len;
                    gap_d   = gap_len;
                    cnt_d   = '0;
                    bcnt_d  = '0;
                    gcnt_d  = '0;
                    state_d = (total == 16'd0) ? S_DONE : S_BURST;
                end
            end
            S_BURST: begin
                if (wr) begin
                    cnt_d = cnt_q + 16'd1;
                    if (last_wr) begin
                        // Final word: data keeps the last written value.
                        state_d = S_DONE;
                    end else begin
                        data_d = data_q + 1'b1;
                        if (burst_end) begin
                            bcnt_d = '0;
                            if (gap_q != 8'd0) begin
                                gcnt_d  = '0;
                                state_d = S_GAP;
                            end
                        end else begin
                            bcnt_d = bcnt_q + BONE;
                        end
                    end
                end
            end
            S_GAP: begin
                if (gcnt_q == gap_q - 8'd1) begin
                    gcnt_d  = '0;
                    bcnt_d  = '0;
                    state_d = S_BURST;
                end else begin
                    gcnt_d = gcnt_q + 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any run immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            total_q <= '0;
            blen_q  <= '0;
            gap_q   <= '0;
            cnt_q   <= '0;
            bcnt_q  <= '0;
            gcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            total_q <= total_d;
            blen_q  <= blen_d;
            gap_q   <= gap_d;
            cnt_q   <= cnt_d;
            bcnt_q  <= bcnt_d;
            gcnt_q  <= gcnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_stim_writer.sv
// Directed bench for fifo_stim_writer.
// Records every accepted write and checks data, timing and counters.
module tb_fifo_stim_writer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  seed = '0;
    logic [15:0] total = '0;
    logic [4:0]  burst_len = '0;
    logic [7:0]  gap_len = '0;
    logic        full = 1'b0;
    logic        wr;
    logic [7:0]  wr_data;
    logic        busy;
    logic        done;
    logic [15:0] wr_count;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int st_cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int full_busy = 0;
    int wr_full = 0;
    bit full_en = 1'b0;
    logic [7:0] wq[$];
    int tq[$];

    fifo_stim_writer #(.B(8), .W(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .seed(seed),
        .total(total),
        .burst_len(burst_len),
        .gap_len(gap_len),
        .full(full),
        .wr(wr),
        .wr_data(wr_data),
        .busy(busy),
        .done(done),
        .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    // Cycle index used to timestamp writes.
    always @(posedge clk) cyc <= cyc + 1;

    // FIFO full window: 5 cycles starting 3 cycles after start.
    always @(posedge clk) begin
        #1;
        full = full_en && (cyc >= st_cyc + 3) && (cyc < st_cyc + 8);
    end

    // Write/done recorder, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n && wr) begin
            wq.push_back(wr_data);
            tq.push_back(cyc);
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (full && busy) full_busy = full_busy + 1;
        if (full && wr) wr_full = wr_full + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (obs === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic clear_rec();
        wq.delete();
        tq.delete();
        done_cnt = 0;
        full_busy = 0;
        wr_full = 0;
    endtask

    task automatic run(input logic [7:0] s, input logic [15:0] t,
                       input logic [4:0] bl, input logic [7:0] gl);
        @(negedge clk);
        #2;
        seed = s;
        total = t;
        burst_len = bl;
        gap_len = gl;
        start = 1'b1;
        st_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", {31'd0, busy}, {31'd0, t != 16'd0});
    endtask

    task automatic wait_done(input string tag);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            #2;
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        check({tag, "_done_seen"}, {31'd0, got}, 32'd1);
    endtask

    task automatic check_seq(input string tag, input logic [7:0] s,
                             input int n);
        int bad;
        logic [7:0] e;
        bad = 0;
        e = s;
        check({tag, "_nwr"}, wq.size(), n);
        for (int i = 0; i < wq.size() && i < n; i++) begin
            if (wq[i] !== e) bad++;
            e = e + 8'd1;
        end
        check({tag, "_data_errs"}, bad, 0);
    endtask

    initial begin
        int bad;
        int n;
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_wr", {31'd0, wr}, 32'd0);
        check("rst_data", {24'd0, wr_data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_count", {16'd0, wr_count}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single burst of 8, no gap
        clear_rec();
        run(8'h41, 16'd8, 5'd8, 8'd0);
        wait_done("t1");
        check_seq("t1", 8'h41, 8);
        check("t1_first_lat", tq[0], st_cyc + 1);
        check("t1_back2back", tq[7] - tq[0], 7);
        check("t1_done_cyc", done_cyc, tq[7] + 1);
        check("t1_count", {16'd0, wr_count}, 32'd8);
        check("t1_busy_in_done", {31'd0, busy}, 32'd0);
        // start during DONE must be ignored
        total = 16'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        check("t1_ign_busy", {31'd0, busy}, 32'd0);
        check("t1_ign_nwr", wq.size(), 8);
        check("t1_done_once", done_cnt, 1);
        check("t1_hold_data", {24'd0, wr_data}, 32'h48);
        check("t1_hold_count", {16'd0, wr_count}, 32'd8);

        // 5 bursts of 4 with 3-cycle gaps
        clear_rec();
        run(8'h01, 16'd20, 5'd4, 8'd3);
        wait_done("t2");
        check_seq("t2", 8'h01, 20);
        bad = 0;
        for (int i = 1; i < tq.size(); i++)
            if (tq[i] - tq[i-1] != ((i % 4 == 0) ? 4 : 1)) bad++;
        check("t2_spacing_errs", bad, 0);
        check("t2_count", {16'd0, wr_count}, 32'd20);

        // full held 5 cycles mid-burst
        clear_rec();
        full_en = 1'b1;
        run(8'h20, 16'd10, 5'd10, 8'd0);
        wait_done("t3");
        full_en = 1'b0;
        check_seq("t3", 8'h20, 10);
        check("t3_stall_len", tq[2] - tq[1], 6);
        check("t3_full_cycles", full_busy, 5);
        check("t3_wr_while_full", wr_full, 0);
        check("t3_count", {16'd0, wr_count}, 32'd10);

        // data wrap and burst_len 0 treated as 1 with gap 1
        clear_rec();
        run(8'hFE, 16'd4, 5'd0, 8'd1);
        wait_done("t4");
        check_seq("t4", 8'hFE, 4);
        check("t4_wrap_val", {24'd0, wq[2]}, 32'h00);
        check("t4_gap1", tq[1] - tq[0], 2);

        // total 0: done pulse only
        clear_rec();
        run(8'h33, 16'd0, 5'd4, 8'd0);
        wait_done("t5");
        @(negedge clk);
        #2;
        check("t5_nwr", wq.size(), 0);
        check("t5_done_once", done_cnt, 1);
        check("t5_count", {16'd0, wr_count}, 32'd0);

        // reset mid-run after 3 writes
        clear_rec();
        run(8'h60, 16'd10, 5'd10, 8'd0);
        n = 0;
        while (wq.size() < 3 && n < 50) begin
            @(negedge clk);
            #2;
            n++;
        end
        rst_n = 1'b0;
        #1;
        check("t6_rst_wr", {31'd0, wr}, 32'd0);
        check("t6_rst_busy", {31'd0, busy}, 32'd0);
        check("t6_rst_count", {16'd0, wr_count}, 32'd0);
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        check("t6_nwr_after_rst", wq.size(), 3);
        clear_rec();
        run(8'h70, 16'd3, 5'd4, 8'd0);
        wait_done("t6b");
        check_seq("t6b", 8'h70, 3);
        check("t6b_count", {16'd0, wr_count}, 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
